// File: rtl/regfile_port_sequencer.sv
// Serialises writeback and operand-read requests onto a register file port with
// combinational read and level-sensitive write; operands return via valid/ready.
module regfile_port_sequencer #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 5,
  parameter int WRITE_CYCLES  = 1,
  parameter int READ_CYCLES   = 1,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rdst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_rsrc1,
  input  logic [ADDR_W-1:0] rd_rsrc2,
  output logic              rd_ready,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [ADDR_W-1:0] rf_rsrc1,
  output logic [ADDR_W-1:0] rf_rsrc2,
  output logic [ADDR_W-1:0] rf_rdst,
  output logic [DATA_W-1:0] rf_in,
  output logic              rf_read,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] WR_LAST    = 4'(WRITE_CYCLES - 1);
  localparam logic [3:0] RD_LAST    = 4'(READ_CYCLES - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_WR_STREAK);

  state_t            state_reg, state_next;
  logic [3:0]        cycle_cnt_reg, cycle_cnt_next;
  logic [3:0]        streak_reg, streak_next;
  logic              rf_read_reg, rf_read_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [ADDR_W-1:0] rf_rdst_reg;
  logic [DATA_W-1:0] rf_in_reg;

  logic wr_done;
  logic rd_done;

  assign wr_done = (state_reg == WRITE) && (cycle_cnt_reg == WR_LAST);
  assign rd_done = (state_reg == READ) && (cycle_cnt_reg == RD_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (wb_ready) begin
          state_next = WRITE;
        end else if (rd_ready) begin
          state_next = READ;
        end
      end
      WRITE: begin
        if (wr_done) begin
          state_next = IDLE;
        end
      end
      READ: begin
        if (rd_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rd_resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grants: write wins unless a waiting read has already seen MAX_WR_STREAK writes.
  always_comb begin
    wb_ready = 1'b0;
    rd_ready = 1'b0;
    if (rst_n && (state_reg == IDLE)) begin
      if (wb_valid && !(rd_valid && (streak_reg == STREAK_MAX))) begin
        wb_ready = 1'b1;
      end else if (rd_valid) begin
        rd_ready = 1'b1;
      end
    end
  end

  always_comb begin
    cycle_cnt_next  = '0;
    streak_next     = streak_reg;
    rf_read_next    = rf_read_reg;
    resp_valid_next = resp_valid_reg;

    if ((state_reg == WRITE && !wr_done) || (state_reg == READ && !rd_done)) begin
      cycle_cnt_next = cycle_cnt_reg + 4'd1;
    end

    if (wb_ready) begin
      rf_read_next = 1'b0;
      streak_next  = rd_valid ? (streak_reg + 4'd1) : 4'd0;
    end else if (rd_ready) begin
      streak_next = 4'd0;
    end

    if (wr_done) begin
      rf_read_next = 1'b1;
    end

    if (rd_done) begin
      resp_valid_next = 1'b1;
    end else if ((state_reg == RESP) && rd_resp_ready) begin
      resp_valid_next = 1'b0;
    end
  end

  // rf_read comes straight from a flop so the write strobe cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg  <= '0;
      streak_reg     <= '0;
      rf_read_reg    <= 1'b1;
      resp_valid_reg <= 1'b0;
      rf_rdst_reg    <= '0;
      rf_in_reg      <= '0;
    end else begin
      cycle_cnt_reg  <= cycle_cnt_next;
      streak_reg     <= streak_next;
      rf_read_reg    <= rf_read_next;
      resp_valid_reg <= resp_valid_next;
      if (wb_ready) begin
        rf_rdst_reg <= wb_rdst;
        rf_in_reg   <= wb_data;
      end
    end
  end

  // One lane per operand: address latched at grant, data captured at the end of READ.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [ADDR_W-1:0] rsrc_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] rsrc_src;
    logic [DATA_W-1:0] data_src;

    assign rsrc_src = (gi == 0) ? rd_rsrc1 : rd_rsrc2;
    assign data_src = (gi == 0) ? rf_out1 : rf_out2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rsrc_reg <= '0;
        data_reg <= '0;
      end else begin
        if (rd_ready) begin
          rsrc_reg <= rsrc_src;
        end
        if (rd_done) begin
          data_reg <= data_src;
        end
      end
    end
  end

  // Output assignments
  assign rf_read       = rf_read_reg;
  assign rf_rdst       = rf_rdst_reg;
  assign rf_in         = rf_in_reg;
  assign rf_rsrc1      = g_lane[0].rsrc_reg;
  assign rf_rsrc2      = g_lane[1].rsrc_reg;
  assign rd_data1      = g_lane[0].data_reg;
  assign rd_data2      = g_lane[1].data_reg;
  assign rd_resp_valid = resp_valid_reg;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Two sequencers (1/1 and 3/2 write/read cycles) share stimulus; each drives its
// own register file and is checked every cycle against a transaction-level timeline model.
module tb_regfile_port_sequencer;

  localparam int NI   = 2;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rdst;
  logic [63:0] wb_data;
  logic        rd_valid;
  logic [4:0]  rd_rsrc1;
  logic [4:0]  rd_rsrc2;
  logic        rd_resp_ready;
  logic        load_en;

  logic        wb_ready      [NI];
  logic        rd_ready      [NI];
  logic        rd_resp_valid [NI];
  logic [63:0] rd_data1      [NI];
  logic [63:0] rd_data2      [NI];
  logic [4:0]  rf_rsrc1      [NI];
  logic [4:0]  rf_rsrc2      [NI];
  logic [4:0]  rf_rdst       [NI];
  logic [63:0] rf_in         [NI];
  logic        rf_read       [NI];
  logic [63:0] rf_out1       [NI];
  logic [63:0] rf_out2       [NI];

  logic [63:0] mem      [NI][32];
  logic [63:0] init_pat [32];

  int checks;
  int errors;

  function automatic int wcy(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int rcy(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    regfile_port_sequencer #(
      .DATA_W(64), .ADDR_W(5),
      .WRITE_CYCLES((gi == 0) ? 1 : 3),
      .READ_CYCLES((gi == 0) ? 1 : 2),
      .MAX_WR_STREAK(MAXS)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_rdst(wb_rdst), .wb_data(wb_data), .wb_ready(wb_ready[gi]),
      .rd_valid(rd_valid), .rd_rsrc1(rd_rsrc1), .rd_rsrc2(rd_rsrc2), .rd_ready(rd_ready[gi]),
      .rd_resp_valid(rd_resp_valid[gi]), .rd_resp_ready(rd_resp_ready),
      .rd_data1(rd_data1[gi]), .rd_data2(rd_data2[gi]),
      .rf_rsrc1(rf_rsrc1[gi]), .rf_rsrc2(rf_rsrc2[gi]), .rf_rdst(rf_rdst[gi]),
      .rf_in(rf_in[gi]), .rf_read(rf_read[gi]),
      .rf_out1(rf_out1[gi]), .rf_out2(rf_out2[gi])
    );
    assign rf_out1[gi] = mem[gi][rf_rsrc1[gi]];
    assign rf_out2[gi] = mem[gi][rf_rsrc2[gi]];
  end

  // Register file behaviour: combinational read, write while rf_read is low.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (load_en) begin
        for (int r = 0; r < 32; r++) mem[i][r] <= init_pat[r];
      end else if (!rf_read[i]) begin
        mem[i][rf_rdst[i]] <= rf_in[i];
      end
    end
  end

  task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Timeline model: each accepted request occupies a window of cycles.
  int          cyc;
  int          free_at [NI];
  int          wr_lo [NI], wr_hi [NI];
  int          rw_lo [NI], rw_hi [NI];
  int          resp_at [NI];
  bit          resp_pend [NI];
  int          streak [NI];
  logic [63:0] model_rf [NI][32];
  logic [4:0]  w_addr [NI], m_rs1 [NI], m_rs2 [NI];
  logic [63:0] w_data [NI], exp_d1 [NI], exp_d2 [NI];

  task automatic model_step(input int i);
    bit idle, e_wb, e_rd, e_rfr, e_rv, in_rw;
    idle  = (cyc >= free_at[i]) && !resp_pend[i];
    e_wb  = idle && wb_valid && !(rd_valid && (streak[i] == MAXS));
    e_rd  = idle && rd_valid && !e_wb;
    e_rfr = !((cyc >= wr_lo[i]) && (cyc <= wr_hi[i]));
    e_rv  = resp_pend[i] && (cyc >= resp_at[i]);
    in_rw = (cyc >= rw_lo[i]) && (cyc <= rw_hi[i]);

    chk("wb_ready", i, 64'(wb_ready[i]), 64'(e_wb));
    chk("rd_ready", i, 64'(rd_ready[i]), 64'(e_rd));
    chk("rf_read", i, 64'(rf_read[i]), 64'(e_rfr));
    chk("rd_resp_valid", i, 64'(rd_resp_valid[i]), 64'(e_rv));
    if (!e_rfr) begin
      chk("rf_rdst", i, 64'(rf_rdst[i]), 64'(w_addr[i]));
      chk("rf_in", i, rf_in[i], w_data[i]);
    end
    if (in_rw) begin
      chk("rf_rsrc1", i, 64'(rf_rsrc1[i]), 64'(m_rs1[i]));
      chk("rf_rsrc2", i, 64'(rf_rsrc2[i]), 64'(m_rs2[i]));
    end
    if (e_rv) begin
      chk("rd_data1", i, rd_data1[i], exp_d1[i]);
      chk("rd_data2", i, rd_data2[i], exp_d2[i]);
    end

    if (e_rv && rd_resp_ready) begin
      resp_pend[i] = 1'b0;
      free_at[i]   = cyc + 1;
      $display("inst%0d cyc %0d RSP %h %h", i, cyc, exp_d1[i], exp_d2[i]);
    end
    if (e_wb) begin
      model_rf[i][wb_rdst] = wb_data;
      w_addr[i]  = wb_rdst;
      w_data[i]  = wb_data;
      wr_lo[i]   = cyc + 1;
      wr_hi[i]   = cyc + wcy(i);
      free_at[i] = cyc + wcy(i) + 1;
      streak[i]  = rd_valid ? streak[i] + 1 : 0;
      $display("inst%0d cyc %0d WR r%0d <= %h", i, cyc, wb_rdst, wb_data);
    end else if (e_rd) begin
      m_rs1[i]     = rd_rsrc1;
      m_rs2[i]     = rd_rsrc2;
      exp_d1[i]    = model_rf[i][rd_rsrc1];
      exp_d2[i]    = model_rf[i][rd_rsrc2];
      rw_lo[i]     = cyc + 1;
      rw_hi[i]     = cyc + rcy(i);
      resp_at[i]   = cyc + rcy(i) + 1;
      resp_pend[i] = 1'b1;
      streak[i]    = 0;
      $display("inst%0d cyc %0d RD r%0d r%0d", i, cyc, rd_rsrc1, rd_rsrc2);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < NI; i++) begin
        free_at[i]   = 0;
        wr_lo[i]     = 1;
        wr_hi[i]     = 0;
        rw_lo[i]     = 1;
        rw_hi[i]     = 0;
        resp_at[i]   = 0;
        resp_pend[i] = 1'b0;
        streak[i]    = 0;
        if (load_en) begin
          for (int r = 0; r < 32; r++) model_rf[i][r] = init_pat[r];
        end
      end
    end else begin
      for (int i = 0; i < NI; i++) model_step(i);
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_rf_read"}, i, 64'(rf_read[i]), 64'd1);
      chk({tag, "_wb_ready"}, i, 64'(wb_ready[i]), 64'd0);
      chk({tag, "_rd_ready"}, i, 64'(rd_ready[i]), 64'd0);
      chk({tag, "_resp_valid"}, i, 64'(rd_resp_valid[i]), 64'd0);
      chk({tag, "_rf_rdst"}, i, 64'(rf_rdst[i]), 64'd0);
      chk({tag, "_rf_in"}, i, rf_in[i], 64'd0);
      chk({tag, "_rd_data1"}, i, rd_data1[i], 64'd0);
    end
  endtask

  int         low_cnt [NI];
  int         lat [NI];
  int         ng [NI];
  logic [9:0] pat [NI];
  logic [9:0] exp_pat;
  int         low_pairs;
  bit         prev_low;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    load_en = 1'b1;
    wb_valid = 1'b1;
    wb_rdst = '0;
    wb_data = '0;
    rd_valid = 1'b0;
    rd_rsrc1 = '0;
    rd_rsrc2 = '0;
    rd_resp_ready = 1'b0;
    for (int r = 0; r < 32; r++) init_pat[r] = {$urandom, $urandom};
    init_pat[0] = 64'd0;

    // Reset state, including grants suppressed while wb_valid is already high
    repeat (3) step();
    reset_checks("reset");
    load_en = 1'b0;
    wb_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Single write r5 <= 0x1234
    wb_valid = 1'b1; wb_rdst = 5'd5; wb_data = 64'h1234;
    #1;
    for (int i = 0; i < NI; i++) chk("dir_wb_ready", i, 64'(wb_ready[i]), 64'd1);
    step();
    wb_valid = 1'b0;
    for (int i = 0; i < NI; i++) low_cnt[i] = 0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (!rf_read[i]) begin
          low_cnt[i]++;
          chk("dir_rf_rdst", i, 64'(rf_rdst[i]), 64'd5);
          chk("dir_rf_in", i, rf_in[i], 64'h1234);
        end
      end
      step();
    end
    chk("write_low_cycles", 0, 64'(low_cnt[0]), 64'd1);
    chk("write_low_cycles", 1, 64'(low_cnt[1]), 64'd3);

    // Read r5/r0, hold the response, then release it
    rd_valid = 1'b1; rd_rsrc1 = 5'd5; rd_rsrc2 = 5'd0;
    #1;
    for (int i = 0; i < NI; i++) chk("dir_rd_ready", i, 64'(rd_ready[i]), 64'd1);
    step();
    rd_valid = 1'b0;
    for (int i = 0; i < NI; i++) lat[i] = 0;
    for (int n = 1; n <= 8; n++) begin
      for (int i = 0; i < NI; i++) if (lat[i] == 0 && rd_resp_valid[i]) lat[i] = n;
      step();
    end
    chk("read_latency", 0, 64'(lat[0]), 64'd2);
    chk("read_latency", 1, 64'(lat[1]), 64'd3);
    for (int i = 0; i < NI; i++) begin
      chk("held_valid", i, 64'(rd_resp_valid[i]), 64'd1);
      chk("held_data1", i, rd_data1[i], 64'h1234);
      chk("held_data2", i, rd_data2[i], 64'd0);
    end
    rd_resp_ready = 1'b1;
    step();
    for (int i = 0; i < NI; i++) chk("valid_cleared", i, 64'(rd_resp_valid[i]), 64'd0);
    rd_resp_ready = 1'b0;

    // Continuous contention: expect W W W W R repeating
    wb_valid = 1'b1; rd_valid = 1'b1; rd_resp_ready = 1'b1;
    for (int i = 0; i < NI; i++) begin ng[i] = 0; pat[i] = '0; end
    low_pairs = 0;
    prev_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      wb_rdst  = 5'($urandom_range(1, 31));
      wb_data  = {$urandom, $urandom};
      rd_rsrc1 = 5'($urandom);
      rd_rsrc2 = 5'($urandom);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (ng[i] < 10 && (wb_ready[i] || rd_ready[i])) begin
          pat[i] = {pat[i][8:0], wb_ready[i]};
          ng[i]++;
        end
      end
      if (!rf_read[0] && prev_low) low_pairs++;
      prev_low = !rf_read[0];
      step();
    end
    exp_pat = 10'b1111011110;
    for (int i = 0; i < NI; i++) chk("grant_pattern", i, 64'(pat[i]), 64'(exp_pat));
    chk("rf_read_low_pairs", 0, 64'(low_pairs), 64'd0);
    wb_valid = 1'b0; rd_valid = 1'b0;
    repeat (8) step();

    // Randomised traffic
    for (int k = 0; k < 2000; k++) begin
      wb_valid      = 1'($urandom);
      rd_valid      = 1'($urandom);
      wb_rdst       = 5'($urandom);
      wb_data       = {$urandom, $urandom};
      rd_rsrc1      = 5'($urandom);
      rd_rsrc2      = ($urandom_range(0, 3) == 0) ? rd_rsrc1 : 5'($urandom);
      rd_resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    wb_valid = 1'b0; rd_valid = 1'b0; rd_resp_ready = 1'b1;
    repeat (10) step();
    rd_resp_ready = 1'b0;

    // Reset asserted inside a write window
    wb_valid = 1'b1; wb_rdst = 5'd9; wb_data = 64'hDEAD_BEEF;
    #1;
    for (int i = 0; i < NI; i++) chk("pre_rst_wb_ready", i, 64'(wb_ready[i]), 64'd1);
    step();
    wb_valid = 1'b0;
    for (int i = 0; i < NI; i++) chk("pre_rst_rf_read", i, 64'(rf_read[i]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NI; i++) begin
        chk("post_rst_wb_ready", i, 64'(wb_ready[i]), 64'd0);
        chk("post_rst_resp_valid", i, 64'(rd_resp_valid[i]), 64'd0);
        chk("post_rst_rf_read", i, 64'(rf_read[i]), 64'd1);
      end
      step();
    end

    // Recover the abandoned register, then read it on both operands
    wb_valid = 1'b1; wb_rdst = 5'd9; wb_data = 64'hABCD;
    step();
    wb_valid = 1'b0;
    repeat (5) step();
    rd_valid = 1'b1; rd_rsrc1 = 5'd9; rd_rsrc2 = 5'd9;
    step();
    rd_valid = 1'b0;
    repeat (5) step();
    for (int i = 0; i < NI; i++) begin
      chk("recover_valid", i, 64'(rd_resp_valid[i]), 64'd1);
      chk("recover_data1", i, rd_data1[i], 64'hABCD);
      chk("recover_data2", i, rd_data2[i], 64'hABCD);
    end
    rd_resp_ready = 1'b1;
    step();
    rd_resp_ready = 1'b0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_port_sequencer.md
Name: regfile_port_sequencer

Overview:
- Initiator for the 32x64 register file port bundle: rsrc1, rsrc2, rdst, in, out1, out2, read.
- On that bundle `read`=1 is a combinational read and `read`=0 is a level-sensitive write of `in` to `rdst`.
- This block serialises writeback requests and operand-read requests onto the bundle. It keeps `read` high except during a controlled write window and returns registered operands through a valid/ready response.
- Sits between decode/writeback and the register file.

Parameters:
- DATA_W, 64: register width.
- ADDR_W, 5: register index width.
- WRITE_CYCLES, 1: cycles `rf_read` is held low per write; legal range 1..15.
- READ_CYCLES, 1: cycles addresses are held before operands are sampled; legal range 1..15.
- MAX_WR_STREAK, 4: consecutive write grants allowed while a read waits; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  writeback request.
- wb_rdst  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback value.
- wb_ready  out  1  writeback accepted when wb_valid&&wb_ready.
- rd_valid  in  1  operand-read request.
- rd_rsrc1  in  ADDR_W  source 1 index.
- rd_rsrc2  in  ADDR_W  source 2 index.
- rd_ready  out  1  read accepted when rd_valid&&rd_ready.
- rd_resp_valid  out  1  operands available.
- rd_resp_ready  in  1  consumer takes operands.
- rd_data1  out  DATA_W  operand 1.
- rd_data2  out  DATA_W  operand 2.
- rf_rsrc1  out  ADDR_W  to register file rsrc1.
- rf_rsrc2  out  ADDR_W  to register file rsrc2.
- rf_rdst  out  ADDR_W  to register file rdst.
- rf_in  out  DATA_W  to register file in.
- rf_read  out  1  to register file read (1=read, 0=write).
- rf_out1  in  DATA_W  from register file out1.
- rf_out2  in  DATA_W  from register file out2.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values, applied immediately on assertion, including mid-operation:
  - state=IDLE, rf_read=1, all rf_* address/data outputs 0.
  - rd_data1/2=0, rd_resp_valid=0, wb_ready=0, rd_ready=0.
  - streak counter 0, cycle counter 0.
  - An in-progress write is abandoned with rf_read forced high; the target register content is then undefined. Pending requests are dropped.
- rf_read is driven from a flop (not decoded combinationally) so it never glitches low. rf_rdst and rf_in are registered and stable for the whole window in which rf_read=0.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - rf_read=1.
  - Grant write if wb_valid, unless rd_valid && streak==MAX_WR_STREAK; otherwise grant read if rd_valid.
  - wb_ready and rd_ready are combinational, asserted only in IDLE for the granted side. At most one is high per cycle.
  - Write accept: latch wb_rdst→rf_rdst and wb_data→rf_in; go WRITE; set rf_read=0 next cycle; streak+1 if rd_valid, else streak=0.
  - Read accept: latch rd_rsrc1/2→rf_rsrc1/2; go READ; streak=0.
- WRITE:
  - rf_read=0 for exactly WRITE_CYCLES cycles, counted by the cycle counter.
  - On the last cycle, rf_read returns to 1 at the next edge, together with IDLE. rf_rdst/rf_in hold their values after the write.
- READ:
  - rf_read=1; addresses held for READ_CYCLES cycles.
  - At the final edge, capture rf_out1→rd_data1 and rf_out2→rd_data2; go RESP.
- RESP:
  - rd_resp_valid=1; rd_data1/2 stable.
  - On rd_resp_ready, clear valid and go IDLE. No new grant is made in that same cycle.
- Latency:
  - Write: accept to IDLE is WRITE_CYCLES+1 cycles.
  - Read: accept to rd_resp_valid is READ_CYCLES+1 cycles. Minimum with defaults is 2.
- Ordering: requests complete in grant order. A read granted after a write to the same index returns the new value, since no bypass is needed.
- Simultaneous wb_valid and rd_valid: write wins until the streak limit, then read wins once.
- rd_resp_ready held high before valid: no effect until RESP.
- rsrc1==rsrc2 is legal; both outputs carry the same value.

Test Plan:
- Reset, then wb_valid with rdst=5, data=0x1234 → wb_ready in IDLE. rf_read=0 for exactly 1 cycle with rf_rdst=5 and rf_in=0x1234; rf_read=1 otherwise.
- After that write, rd_valid with rsrc1=5, rsrc2=0 (r0 preloaded 0) → rd_resp_valid 2 cycles after accept, rd_data1=0x1234, rd_data2=0.
- Hold rd_resp_ready=0 for 3 cycles in RESP → valid and data stable. Raise it → valid clears next cycle and state returns to IDLE.
- wb_valid and rd_valid held continuously with MAX_WR_STREAK=4 → grant pattern is 4 writes, then 1 read, repeating. rf_read is never low for 2 consecutive cycles.
- WRITE_CYCLES=3, READ_CYCLES=2 → rf_read low for 3 cycles per write; read response arrives 3 cycles after accept.
- Assert rst_n=0 in the middle of a WRITE window → rf_read=1 immediately, without waiting for a clock edge. All outputs take their reset values; no wb_ready or rd_resp_valid appears after release until a new request arrives.
